key_conditioner: RTL and testbench

//   Conditions the raw push-buttons (record / play / stop) before they reach the top-level

---
 rtl/key_conditioner_if.sv | 29 ++
 rtl/key_conditioner.sv | 179 +++++++++++++++++
 tb/tb_key_conditioner.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Push-button bundle between the raw key pins and the key conditioner.
//   key_n     : raw buttons, active-low, asynchronous to the conditioner clock
//   key_pulse : one-cycle pulse per accepted press (plus repeats when enabled)
//   key_level : debounced level, 1 = pressed
//   key_long  : one-cycle pulse when a press has been held long enough
// master drives the raw keys and consumes the conditioned outputs;
// slave is the conditioner side.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_long;

  modport master (
    output key_n,
    input  key_pulse,
    input  key_level,
    input  key_long
  );

  modport slave (
    input  key_n,
    output key_pulse,
    output key_level,
    output key_long
  );
endinterface

// File: rtl/key_conditioner.sv
// Key conditioner for the recorder/player push-buttons (record / play / stop).
// Per key: 2-flop synchronizer, counter debounce, one-cycle press pulse and
// a one-cycle long-press pulse. Outputs feed the control FSM directly.
//
// Ports:
//   i_clk    : clock, all logic on posedge
//   i_rst_n  : synchronous reset, active-low
//   keys     : key_conditioner_if.slave (key_n in; key_pulse/key_level/key_long out)
//
// Optional feature: define KEY_AUTO_REPEAT_EN to emit repeat press pulses every
// REPEAT_CYCLES while a long press is held. Without it S_LONG is silent.
//
// state        | meaning
// S_RELEASED   | key up, waiting for a press (only once a release has been seen)
// S_PRESS_DB   | press seen, counting stable pressed cycles
// S_PRESSED    | press accepted, counting hold time toward long press
// S_LONG       | long press reported, holding
// S_RELEASE_DB | release seen, counting stable released cycles
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 1048576,
  parameter int REPEAT_CYCLES   = 262144
) (
  input logic          i_clk,
  input logic          i_rst_n,
  key_conditioner_if.slave keys
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`else
  // REPEAT_CYCLES has no effect in this build.
  if (REPEAT_CYCLES < 0) begin : g_repeat_unused
  end
`endif

  typedef enum logic [2:0] {
    S_RELEASED,
    S_PRESS_DB,
    S_PRESSED,
    S_LONG,
    S_RELEASE_DB
  } state_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  // sync_vld[1] marks that sync2 carries a real sample rather than the reset
  // value; until then a "released" reading must not arm the keys.
  logic [1:0]          sync_vld;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1    <= '1;
      sync2    <= '1;
      sync_vld <= '0;
    end else begin
      sync1    <= keys.key_n;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    state_t            state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_flag;
    logic              armed;
    logic              pulse;
    logic              level;
    logic              long_pulse;
    logic              k;
`ifdef KEY_AUTO_REPEAT_EN
    logic [REP_W-1:0]  rep_cnt;
`endif

    assign k = ~sync2[g];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        state      <= S_RELEASED;
        db_cnt     <= '0;
        hold_cnt   <= '0;
        long_flag  <= 1'b0;
        armed      <= 1'b0;
        pulse      <= 1'b0;
        level      <= 1'b0;
        long_pulse <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        rep_cnt    <= '0;
`endif
      end else begin
        pulse      <= 1'b0;
        long_pulse <= 1'b0;
        // A key held through reset stays ignored until it is seen released.
        if (!k && sync_vld[1]) armed <= 1'b1;

        case (state)
          S_RELEASED: begin
            if (k && armed) begin
              state  <= S_PRESS_DB;
              db_cnt <= DB_W'(1);
            end
          end
          S_PRESS_DB: begin
            if (!k) begin
              state  <= S_RELEASED;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state     <= S_PRESSED;
              level     <= 1'b1;
              pulse     <= 1'b1;
              hold_cnt  <= '0;
              long_flag <= 1'b0;
              db_cnt    <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          S_PRESSED: begin
            if (!k) begin
              state  <= S_RELEASE_DB;
              db_cnt <= DB_W'(1);
            end else if (hold_cnt == HOLD_LAST) begin
              state      <= S_LONG;
              long_pulse <= 1'b1;
              long_flag  <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          S_LONG: begin
            if (!k) begin
              state  <= S_RELEASE_DB;
              db_cnt <= DB_W'(1);
            end else begin
`ifdef KEY_AUTO_REPEAT_EN
              if (rep_cnt == REP_LAST) begin
                pulse   <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
`endif
            end
          end
          S_RELEASE_DB: begin
            if (k) begin
              // Release bounce: resume where we were, counters untouched.
              state  <= long_flag ? S_LONG : S_PRESSED;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state  <= S_RELEASED;
              level  <= 1'b0;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state <= S_RELEASED;
        endcase
      end
    end

    assign keys.key_pulse[g] = pulse;
    assign keys.key_level[g] = level;
    assign keys.key_long[g]  = long_pulse;
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;
  localparam int NK = 3;
  localparam int DB = 4;
  localparam int LG = 16;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  key_conditioner_if #(.NUM_KEYS(NK)) bus ();

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .keys   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: run-length debounce on the 2-cycle delayed key.
  // Pipeline entries: -1 unknown (just after reset), 0 released, 1 pressed.
  int m_p1[NK], m_p2[NK], m_lvl[NK], m_run[NK], m_hold[NK], m_lng[NK], m_rep[NK], m_arm[NK];
  logic [NK-1:0] exp_pulse, exp_level, exp_long;

  always @(posedge clk) begin
    for (int i = 0; i < NK; i++) begin
      int k;
      exp_pulse[i] = 1'b0;
      exp_long[i]  = 1'b0;
      if (!rst_n) begin
        m_p1[i] = -1; m_p2[i] = -1; m_lvl[i] = 0; m_run[i] = 0;
        m_hold[i] = 0; m_lng[i] = 0; m_rep[i] = 0; m_arm[i] = 0;
      end else begin
        k = m_p2[i];
        m_p2[i] = m_p1[i];
        m_p1[i] = bus.key_n[i] ? 0 : 1;
        if (m_lvl[i] == 0) begin
          if (k != 1) m_run[i] = 0;
          else if (m_arm[i] != 0) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
              m_lvl[i] = 1; exp_pulse[i] = 1'b1; m_run[i] = 0; m_hold[i] = 0; m_lng[i] = 0;
            end
          end
        end else if (k != 1) begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_lvl[i] = 0; m_run[i] = 0; end
        end else if (m_run[i] > 0) begin
          m_run[i] = 0;
        end else if (m_lng[i] == 0) begin
          m_hold[i]++;
          if (m_hold[i] == LG) begin m_lng[i] = 1; exp_long[i] = 1'b1; m_rep[i] = 0; end
        end else begin
`ifdef KEY_AUTO_REPEAT_EN
          m_rep[i]++;
          if (m_rep[i] == RP) begin exp_pulse[i] = 1'b1; m_rep[i] = 0; end
`endif
        end
        if (k == 0) m_arm[i] = 1;
      end
      exp_level[i] = (m_lvl[i] != 0);
    end
  end

  task automatic step(input logic [NK-1:0] kn);
    bus.key_n = kn;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int npulse;
    rst_n = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step(3'b000);
      checks++;
      if ({bus.key_pulse, bus.key_level, bus.key_long} !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got p=%b l=%b g=%b exp all 0", j, bus.key_pulse, bus.key_level, bus.key_long);
      end
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      step(3'b000);
      checks++;
      if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b000) begin
        errors++;
        $display("FAIL held_through_reset cycle %0d got p=%b l=%b exp 000/000", j, bus.key_pulse, bus.key_level);
      end
    end
    for (int j = 1; j <= 8; j++) step(3'b001);
    npulse = 0;
    for (int j = 1; j <= 12; j++) begin
      step(3'b000);
      if (bus.key_pulse[0] === 1'b1) npulse++;
      checks++;
      if (bus.key_pulse[2:1] !== 2'b00) begin
        errors++;
        $display("FAIL held_keys_pulse cycle %0d got %b exp 00", j, bus.key_pulse[2:1]);
      end
    end
    checks++;
    if (npulse != 1) begin
      errors++;
      $display("FAIL repress_after_reset pulses got %0d exp 1", npulse);
    end
    for (int j = 1; j <= 10; j++) step(3'b111);
  endtask

  task automatic test_clean_press;
    for (int j = 1; j <= 12; j++) begin
      step(3'b101);
      checks++;
      if (bus.key_pulse !== ((j == 6) ? 3'b010 : 3'b000) || bus.key_level !== ((j >= 6) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL clean_press cycle %0d got p=%b l=%b", j, bus.key_pulse, bus.key_level);
      end
    end
    for (int j = 1; j <= 10; j++) begin
      step(3'b111);
      checks++;
      if (bus.key_pulse !== 3'b000 || bus.key_level !== ((j < 6) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL clean_release cycle %0d got p=%b l=%b", j, bus.key_pulse, bus.key_level);
      end
    end
  endtask

  task automatic test_bounce;
    logic [14:0] pat;
    pat = 15'b111111110001000;  // bit j: raw key0 for step j (0 = pressed)
    for (int j = 0; j < 15; j++) begin
      step({2'b11, pat[j]});
      checks++;
      if (bus.key_pulse !== 3'b000 || bus.key_level !== 3'b000) begin
        errors++;
        $display("FAIL bounce_glitch step %0d got p=%b l=%b exp 000/000", j, bus.key_pulse, bus.key_level);
      end
    end
    for (int j = 1; j <= 10; j++) begin
      step(3'b110);
      checks++;
      if (bus.key_pulse !== ((j == 6) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL bounce_stable cycle %0d got %b", j, bus.key_pulse);
      end
    end
    for (int j = 1; j <= 10; j++) step(3'b111);
  endtask

  task automatic test_long_press;
    logic [NK-1:0] ep;
    for (int j = 1; j <= 40; j++) begin
      step(3'b011);
      ep = (j == 6) ? 3'b100 : 3'b000;
`ifdef KEY_AUTO_REPEAT_EN
      if (j == 30 || j == 38) ep = 3'b100;
`endif
      checks++;
      if (bus.key_pulse !== ep || bus.key_long !== ((j == 22) ? 3'b100 : 3'b000)
          || bus.key_level !== ((j >= 6) ? 3'b100 : 3'b000)) begin
        errors++;
        $display("FAIL long_press cycle %0d got p=%b g=%b l=%b exp p=%b", j, bus.key_pulse, bus.key_long, bus.key_level, ep);
      end
    end
    for (int j = 1; j <= 10; j++) begin
      step(3'b111);
      checks++;
      if (bus.key_pulse !== 3'b000 || bus.key_level !== ((j < 6) ? 3'b100 : 3'b000)) begin
        errors++;
        $display("FAIL long_release cycle %0d got p=%b l=%b", j, bus.key_pulse, bus.key_level);
      end
    end
  endtask

  task automatic test_release_bounce_long;
    logic [NK-1:0] ep;
    for (int j = 1; j <= 24; j++) step(3'b011);
    checks++;
    if (bus.key_level !== 3'b100) begin
      errors++;
      $display("FAIL rb_setup level got %b exp 100", bus.key_level);
    end
    for (int j = 1; j <= 14; j++) begin
      step((j <= 2) ? 3'b111 : 3'b011);
      ep = 3'b000;
`ifdef KEY_AUTO_REPEAT_EN
      if (j == 9) ep = 3'b100;
`endif
      checks++;
      if (bus.key_level !== 3'b100 || bus.key_long !== 3'b000 || bus.key_pulse !== ep) begin
        errors++;
        $display("FAIL release_bounce cycle %0d got p=%b g=%b l=%b exp p=%b", j, bus.key_pulse, bus.key_long, bus.key_level, ep);
      end
    end
    for (int j = 1; j <= 10; j++) step(3'b111);
    checks++;
    if (bus.key_level !== 3'b000) begin
      errors++;
      $display("FAIL rb_final level got %b exp 000", bus.key_level);
    end
  endtask

  task automatic test_simultaneous;
    for (int j = 1; j <= 10; j++) begin
      step(3'b010);
      checks++;
      if (bus.key_pulse !== ((j == 6) ? 3'b101 : 3'b000)) begin
        errors++;
        $display("FAIL simultaneous cycle %0d got %b", j, bus.key_pulse);
      end
    end
    for (int j = 1; j <= 10; j++) step(3'b111);
  endtask

  task automatic test_random;
    logic [NK-1:0] cur;
    int div[3] = '{3, 8, 30};
    cur = 3'b111;
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 800; s++) begin
        for (int i = 0; i < NK; i++)
          if ($urandom_range(div[p] - 1, 0) == 0) cur[i] = ~cur[i];
        rst_n = !(p == 1 && s >= 400 && s < 403);
        step(cur);
        checks++;
        if (bus.key_pulse !== exp_pulse || bus.key_level !== exp_level || bus.key_long !== exp_long) begin
          errors++;
          $display("FAIL random phase %0d step %0d got p=%b l=%b g=%b exp p=%b l=%b g=%b",
                   p, s, bus.key_pulse, bus.key_level, bus.key_long, exp_pulse, exp_level, exp_long);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus.key_n = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_bounce_long();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
